elevator_scheduler: RTL and testbench
=====================================

Name: elevator_scheduler

Overview:
- Request scheduler and sequencer for the 2-bit elevator car-position datapath.
- Latches per-floor call requests and moves the car one floor per travel interval using SCAN ordering: keep going while calls remain ahead, otherwise reverse.
- Opens the door on arrival at a called floor and times the dwell.
- Sits between the floor call buttons and the car position/door drivers.

Parameters:
- NUM_FLOORS, 4: number of floors. Legal range 2..4 with FLOOR_W = 2.
- FLOOR_W, 2: width of a floor index, equal to $clog2(NUM_FLOORS).
- TRAVEL_CYC, 4: clock cycles to move one floor. Must be ≥ 1.
- DOOR_CYC, 3: clock cycles the door stays open. Must be ≥ 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_FLOORS  floor call requests, one bit per floor; a level or a single-cycle pulse both register
- cf  out  FLOOR_W  current floor
- dir_up  out  1  travel direction: 1 = up, 0 = down
- moving  out  1  high while in MOVE_UP or MOVE_DOWN
- door_open  out  1  high while in DOOR
- arrive  out  1  one-cycle pulse on the first DOOR cycle
- pending  out  NUM_FLOORS  latched, not-yet-served calls

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: state = IDLE, cf = 0, dir_up = 1, moving = 0, door_open = 0, arrive = 0, pending = 0, timers = 0.
- Reset mid-travel or mid-dwell aborts immediately to the reset values. Requests are lost.
- Request merge: eff = pending | req. Every edge: pending <= eff & ~clr, where clr has the bit for cf set on any edge that enters or restarts DOOR.
- Derived terms: above = any eff bit at an index > cf; below = any eff bit at an index < cf; here = eff[cf].
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- IDLE:
  - here → DOOR.
  - else, if above and (dir_up or !below) → MOVE_UP, dir_up <= 1.
  - else, if below → MOVE_DOWN, dir_up <= 0.
  - else stay in IDLE.
  - Response latency from a request to leaving IDLE: 1 cycle.
- MOVE_UP / MOVE_DOWN:
  - The travel counter starts at 0 on entry.
  - When the counter reaches TRAVEL_CYC-1, cf increments or decrements at that edge and the counter restarts.
  - At that same edge: if eff[new cf] → DOOR; else if calls remain ahead in the current direction → stay in the state; else → IDLE.
- DOOR:
  - Entry asserts arrive for one cycle and clears pending[cf].
  - door_open is high for DOOR_CYC cycles.
  - A req for cf arriving during DOOR is absorbed (never latched) and restarts the dwell timer.
  - On timer expiry, apply the IDLE direction rule with "here" ignored. No calls → IDLE.
- Bounds:
  - cf never leaves 0..NUM_FLOORS-1.
  - MOVE_UP is never entered at the top floor; MOVE_DOWN is never entered at floor 0.
  - In RTL, req bits with index ≥ NUM_FLOORS are ignored.
- Simultaneous events:
  - A req for the floor being reached at the arrival edge is served at that arrival (stop).
  - Requests for floors behind the car are latched and served after reversal.
  - Multiple new requests in one cycle are all latched.
- Invariants (bench must check):
  - moving and door_open are never both high.
  - cf changes only on a travel-counter expiry, by exactly ±1.

Decomposition:
- Package elevator_pkg holds the state_t enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR), FLOOR_W, and the default timing constants.
- Sub-module elev_timer: a loadable down-counter with load, restart and expire outputs. It is instantiated twice, once for travel and once for door dwell.
- The top level holds the FSM, the pending register and the above/below reduction logic.

Test Plan:
1. Reset; at cycle 0 pulse req = 4'b0100 → MOVE_UP from edge 1; cf = 1 at edge 5; cf = 2 with door_open = 1 and arrive = 1 at edge 9; door_open stays high for 3 cycles; then IDLE with pending = 0.
2. cf = 0, req = 4'b1000; while cf = 1 and travelling upward, pulse req[2] → stops at floor 2 (door for 3 cycles), then continues to floor 3. pending is 0 at the end.
3. cf = 2 heading up, pending = {floor 0, floor 3} → serves floor 3 first, then reverses. dir_up goes 0 and the car reaches floor 0 at 3×TRAVEL_CYC cycles after leaving floor 3.
4. In IDLE at cf = 1, req[1] held for 1 cycle → DOOR the next cycle with arrive = 1, no movement. Re-pulse req[1] on the 2nd door cycle → door_open is extended to 3 cycles from the re-pulse.
5. Assert rst_n = 0 asynchronously mid-MOVE_UP with cf = 1 and pending ≠ 0 → all outputs take their reset values without waiting for a clock edge. No motion after release until a new req.
6. Request all floors (4'b1111) at cf = 0 → stops at 0, 1, 2, 3 in order, with arrive pulsing 4 times. The moving and door_open exclusivity invariant holds throughout.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and default timing for the elevator request scheduler.
// Default constants are used by the top's parameters.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  localparam int DEF_NUM_FLOORS = 4;
  localparam int DEF_FLOOR_W    = 2;
  localparam int DEF_TRAVEL_CYC = 4;
  localparam int DEF_DOOR_CYC   = 3;

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter: load presets LEN-1, run counts down, expire fires at zero
// and the counter restarts itself so back-to-back intervals need no extra load.
module elev_timer #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] TOP = CW'(LEN - 1);

  logic [CW-1:0] cnt;

  assign expire = run && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TOP;
    end else if (run) begin
      cnt <= expire ? TOP : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-ordered elevator scheduler: latches floor calls, steps the car one floor per
// travel interval and holds the door open for a dwell on each served floor.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W,
  parameter int TRAVEL_CYC = DEF_TRAVEL_CYC,
  parameter int DOOR_CYC   = DEF_DOOR_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]    cf,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int NF = 1 << FLOOR_W;
  localparam logic [NF-1:0] VALID = NF'((64'd1 << NUM_FLOORS) - 64'd1);

  state_t          state, nstate;
  logic [NF-1:0]   pend, eff, clr;
  logic [FLOOR_W-1:0] ncf;
  logic            ndir, enter_door, travel_load, door_load;
  logic            travel_exp, door_exp;
  logic            here, above, below, ahead_up, ahead_dn, go_up, go_dn;

  assign eff     = pend | (NF'(req) & VALID);
  assign here    = eff[cf];
  assign above   = |(eff & NF'(~((32'd2 << cf) - 32'd1)));
  assign below   = |(eff & NF'((32'd1 << cf) - 32'd1));
  // Calls beyond the floor about to be reached, for deciding whether to keep going.
  assign ahead_up = |(eff & NF'(~((32'd4 << cf) - 32'd1)));
  assign ahead_dn = |(eff & NF'(((32'd1 << cf) - 32'd1) >> 1));
  assign go_up   = above && (dir_up || !below);
  assign go_dn   = !go_up && below;
  assign pending = pend[NUM_FLOORS-1:0];

  always_comb begin
    nstate      = state;
    ncf         = cf;
    ndir        = dir_up;
    clr         = '0;
    enter_door  = 1'b0;
    travel_load = 1'b0;
    door_load   = 1'b0;
    case (state)
      IDLE: begin
        if (here) begin
          nstate     = DOOR;
          enter_door = 1'b1;
          door_load  = 1'b1;
          clr[cf]    = 1'b1;
        end else if (go_up) begin
          nstate      = MOVE_UP;
          ndir        = 1'b1;
          travel_load = 1'b1;
        end else if (go_dn) begin
          nstate      = MOVE_DOWN;
          ndir        = 1'b0;
          travel_load = 1'b1;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (travel_exp) begin
          ncf = (state == MOVE_UP) ? cf + 1'b1 : cf - 1'b1;
          if (eff[ncf]) begin
            nstate     = DOOR;
            enter_door = 1'b1;
            door_load  = 1'b1;
            clr[ncf]   = 1'b1;
          end else if (!((state == MOVE_UP) ? ahead_up : ahead_dn)) begin
            nstate = IDLE;
          end
        end
      end
      DOOR: begin
        // A call for this floor while open is absorbed and extends the dwell.
        if (here) begin
          door_load = 1'b1;
          clr[cf]   = 1'b1;
        end else if (door_exp) begin
          if (go_up) begin
            nstate      = MOVE_UP;
            ndir        = 1'b1;
            travel_load = 1'b1;
          end else if (go_dn) begin
            nstate      = MOVE_DOWN;
            ndir        = 1'b0;
            travel_load = 1'b1;
          end else begin
            nstate = IDLE;
          end
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cf        <= '0;
      dir_up    <= 1'b1;
      moving    <= 1'b0;
      door_open <= 1'b0;
      arrive    <= 1'b0;
      pend      <= '0;
    end else begin
      state     <= nstate;
      cf        <= ncf;
      dir_up    <= ndir;
      moving    <= (nstate == MOVE_UP) || (nstate == MOVE_DOWN);
      door_open <= (nstate == DOOR);
      arrive    <= enter_door;
      pend      <= eff & ~clr & VALID;
    end
  end

  elev_timer #(.LEN(TRAVEL_CYC)) u_travel (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (travel_load),
    .run    (moving),
    .expire (travel_exp)
  );

  elev_timer #(.LEN(DOOR_CYC)) u_door (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (door_load),
    .run    (door_open),
    .expire (door_exp)
  );

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: per-cycle comparison against a call-list model plus
// directed scenarios with hand-computed edge timings.
module tb_elevator_scheduler;

  localparam int TRAVEL = 4;
  localparam int DOORC  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [1:0] cf;
  logic       dir_up, moving, door_open, arrive;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;
  int ecnt;
  int arr_cnt = 0;

  elevator_scheduler #(
    .NUM_FLOORS (4),
    .FLOOR_W    (2),
    .TRAVEL_CYC (TRAVEL),
    .DOOR_CYC   (DOORC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .cf        (cf),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .arrive    (arrive),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a list of outstanding calls, a floor number and two countdowns.
  bit m_call[4];
  int m_floor, m_door, m_travel;
  bit m_up, m_mov, m_arr;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_call[i] = 1'b0;
    m_floor = 0; m_up = 1'b1; m_mov = 1'b0; m_arr = 1'b0; m_door = 0; m_travel = 0;
  endtask

  task automatic m_open();
    m_call[m_floor] = 1'b0;
    m_door = DOORC;
    m_arr  = 1'b1;
    m_mov  = 1'b0;
  endtask

  task automatic m_choose();
    bit a, b;
    a = 1'b0; b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_call[i] && i > m_floor) a = 1'b1;
      if (m_call[i] && i < m_floor) b = 1'b1;
    end
    if (a && (m_up || !b)) begin m_up = 1'b1; m_mov = 1'b1; m_travel = TRAVEL; end
    else if (b) begin m_up = 1'b0; m_mov = 1'b1; m_travel = TRAVEL; end
    else m_mov = 1'b0;
  endtask

  function automatic bit m_ahead();
    for (int i = 0; i < 4; i++)
      if (m_call[i] && (m_up ? (i > m_floor) : (i < m_floor))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_step(logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) m_call[i] = 1'b1;
    m_arr = 1'b0;
    if (m_door > 0) begin
      if (m_call[m_floor]) begin
        m_call[m_floor] = 1'b0;
        m_door = DOORC;
      end else begin
        m_door--;
        if (m_door == 0) m_choose();
      end
    end else if (m_mov) begin
      m_travel--;
      if (m_travel == 0) begin
        m_floor += m_up ? 1 : -1;
        if (m_call[m_floor]) m_open();
        else if (m_ahead()) m_travel = TRAVEL;
        else m_mov = 1'b0;
      end
    end else if (m_call[m_floor]) m_open();
    else m_choose();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step(req);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else ecnt <= ecnt + 1;
  end

  logic [9:0] exp_v, act_v;
  logic [3:0] m_pend;
  logic [1:0] prev_cf = 2'd0;
  logic       prev_mov = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) m_pend[i] = m_call[i];
      exp_v = {2'(m_floor), m_up, m_mov, (m_door > 0), m_arr, m_pend};
      act_v = {cf, dir_up, moving, door_open, arrive, pending};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_cmp t=%0t {cf,dir,mov,door,arr,pend}: got %b expected %b",
                 $time, act_v, exp_v);
      end
      chk("excl_mov_door", int'(moving && door_open), 0);
      if (cf != prev_cf)
        chk("cf_step", int'(prev_mov && ((cf == prev_cf + 2'd1) || (cf + 2'd1 == prev_cf))), 1);
      if (arrive) arr_cnt++;
    end
    prev_cf  = cf;
    prev_mov = moving;
  end

  task automatic at_edge(int k);
    while (ecnt < k) @(negedge clk);
  endtask

  // Reset, then present r for exactly the cycle before edge 1.
  task automatic launch(logic [3:0] r);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req   = r;
    @(negedge clk);
    req   = 4'b0000;
  endtask

  task automatic pulse(logic [3:0] r);
    req = r;
    @(negedge clk);
    req = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_vec", int'({cf, dir_up, moving, door_open, arrive, pending}), int'(10'b00_1_0_0_0_0000));

    // 1: single call two floors up
    launch(4'b0100);
    chk("t1_mov_e1", moving, 1);
    at_edge(4);  chk("t1_cf_e4", cf, 0);
    at_edge(5);  chk("t1_cf_e5", cf, 1);
    at_edge(9);  chk("t1_cf_e9", cf, 2); chk("t1_door_e9", door_open, 1); chk("t1_arr_e9", arrive, 1);
    at_edge(10); chk("t1_arr_e10", arrive, 0); chk("t1_door_e10", door_open, 1);
    at_edge(11); chk("t1_door_e11", door_open, 1);
    at_edge(12); chk("t1_door_e12", door_open, 0); chk("t1_pend_e12", pending, 0);

    // 2: call for floor 2 added while passing floor 1
    launch(4'b1000);
    at_edge(5);  chk("t2_cf_e5", cf, 1);
    pulse(4'b0100);
    chk("t2_pend_e6", pending, 4'b1100);
    at_edge(9);  chk("t2_cf_e9", cf, 2); chk("t2_arr_e9", arrive, 1);
    at_edge(12); chk("t2_mov_e12", moving, 1);
    at_edge(16); chk("t2_cf_e16", cf, 3); chk("t2_door_e16", door_open, 1);
    at_edge(19); chk("t2_pend_e19", pending, 0); chk("t2_idle_e19", int'({moving, door_open}), 0);

    // 3: calls on both sides, finish upward then reverse
    launch(4'b0100);
    at_edge(9);
    pulse(4'b1001);
    chk("t3_pend_e10", pending, 4'b1001);
    at_edge(12); chk("t3_dir_e12", dir_up, 1);
    at_edge(16); chk("t3_cf_e16", cf, 3); chk("t3_pend_e16", pending, 4'b0001);
    at_edge(19); chk("t3_dir_e19", dir_up, 0); chk("t3_mov_e19", moving, 1);
    at_edge(30); chk("t3_cf_e30", cf, 1);
    at_edge(31); chk("t3_cf_e31", cf, 0); chk("t3_arr_e31", arrive, 1);
    at_edge(34); chk("t3_pend_e34", pending, 0); chk("t3_door_e34", door_open, 0);

    // 4: call at current floor, then dwell extension
    launch(4'b0010);
    at_edge(5);  chk("t4_cf_e5", cf, 1);
    at_edge(8);  chk("t4_idle_e8", int'({moving, door_open}), 0);
    pulse(4'b0010);
    chk("t4_arr_e9", arrive, 1); chk("t4_mov_e9", moving, 0); chk("t4_cf_e9", cf, 1);
    at_edge(10);
    pulse(4'b0010);
    chk("t4_arr_e11", arrive, 0); chk("t4_pend_e11", pending, 0);
    at_edge(13); chk("t4_door_e13", door_open, 1);
    at_edge(14); chk("t4_door_e14", door_open, 0);

    // 5: asynchronous reset mid-travel
    launch(4'b1000);
    at_edge(6);
    chk("t5_pre_cf", cf, 1); chk("t5_pre_pend", pending, 4'b1000);
    #2 rst_n = 1'b0;
    #1 chk("t5_async", int'({cf, dir_up, moving, door_open, arrive, pending}), int'(10'b00_1_0_0_0_0000));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_still", int'({cf, moving, pending}), 0);

    // 6: every floor called at once
    arr_cnt = 0;
    launch(4'b1111);
    chk("t6_arr_e1", arrive, 1); chk("t6_pend_e1", pending, 4'b1110);
    at_edge(8);  chk("t6_cf_e8", cf, 1); chk("t6_door_e8", door_open, 1);
    at_edge(15); chk("t6_cf_e15", cf, 2);
    at_edge(22); chk("t6_cf_e22", cf, 3); chk("t6_door_e22", door_open, 1);
    at_edge(26); chk("t6_arr_cnt", arr_cnt, 4); chk("t6_pend_e26", pending, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
